aes_round_ctrl: RTL

Iterative AES-128 encryption sequencer that sits directly downstream of aes_key_expand. It drives the round index and cipher key into the key-expansion stage and consumes the round_key it returns. It also registers the cipher state and applies AddRoundKey itself. SubBytes/ShiftRows/MixColumns live in an external combinational round-function block that this controller feeds. One 128-bit block is processed at a time, with valid/ready handshakes on input and output.

---
 rtl/aes_pkg.sv | 9 +
 rtl/aes_round_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, block type and controller state encoding.
package aes_pkg;
  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;

  typedef logic [AES_BLK_W-1:0] aes_block_t;

  typedef enum logic [1:0] {IDLE, ADDK0, RUN, DONE} aes_ctrl_st_t;
endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: FSM, round counter, cipher state and AddRoundKey.
// Defining AES_ROUND_CTRL_CNT_EN adds the blk_count output handshake counter.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR      = AES_NR,
  parameter int ROUND_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_block,
  input  logic [127:0]       in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_block,
  output logic [ROUND_W-1:0] round,
  output logic [127:0]       key_out,
  input  logic [127:0]       round_key,
  output logic [127:0]       rf_state,
  output logic               rf_final,
`ifdef AES_ROUND_CTRL_CNT_EN
  output logic [31:0]        blk_count,
`endif
  input  logic [127:0]       rf_result
);

  localparam logic [ROUND_W-1:0] LP_LAST = ROUND_W'(NR);

  aes_ctrl_st_t       r_st;
  aes_ctrl_st_t       w_st_nxt;
  logic [127:0]       r_state;
  logic [127:0]       r_key;
  logic [ROUND_W-1:0] r_round;
  logic               w_accept;
  logic               w_last;

  // Handshake outputs are forced low while reset is asserted, whatever the state.
  assign in_ready  = rst_n && (r_st == IDLE);
  assign out_valid = rst_n && (r_st == DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_round == LP_LAST);

  assign round     = r_round;
  assign key_out   = r_key;
  assign rf_state  = r_state;
  assign out_block = r_state;
  assign rf_final  = (r_st == RUN) && w_last;

  always_comb begin
    w_st_nxt = r_st;
    unique case (r_st)
      IDLE:    if (w_accept) w_st_nxt = ADDK0;
      ADDK0:   w_st_nxt = RUN;
      RUN:     if (w_last) w_st_nxt = DONE;
      DONE:    if (out_ready) w_st_nxt = IDLE;
      default: w_st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_st <= IDLE;
    else        r_st <= w_st_nxt;
  end

  // Round counter saturates at NR; it only returns to 0 when DONE hands off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_round <= '0;
      r_state <= '0;
      r_key   <= '0;
    end else begin
      case (r_st)
        IDLE: begin
          if (w_accept) begin
            r_state <= in_block;
            r_key   <= in_key;
          end
        end
        ADDK0: begin
          r_state <= r_state ^ round_key;
          r_round <= ROUND_W'(1);
        end
        RUN: begin
          r_state <= rf_result ^ round_key;
          if (!w_last) r_round <= r_round + ROUND_W'(1);
        end
        DONE: begin
          if (out_ready) r_round <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef AES_ROUND_CTRL_CNT_EN
  logic [31:0] r_blk_count;

  always_ff @(posedge clk) begin
    if (!rst_n)                      r_blk_count <= '0;
    else if (out_valid && out_ready) r_blk_count <= r_blk_count + 32'd1;
  end

  assign blk_count = r_blk_count;
`endif

endmodule
